ioctl_rom_router: RTL and testbench

Parametrised successor to the single-index download capture in the arcade top level. It sits between `hps_io`'s ioctl port and the core's ROM/config storage. ROM-index writes are split into NUM_REGIONS address windows, each with its own strobe and a region-local address. Config-index bytes are captured into a multi-byte register. A download/hold state machine produces the core hold signal and a load-complete flag.

---
 rtl/ioctl_rom_router.sv | 167 ++++++++++++++++
 tb/tb_ioctl_rom_router.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_router.sv
// Routes hps_io ioctl downloads into per-region ROM strobes and a config register, and sequences core hold.
// Optional ROM_ROUTER_CHECKSUM_EN adds a 16-bit running sum of routed ROM bytes on port checksum.
module ioctl_rom_router #(
  parameter int                            NUM_REGIONS = 4,
  parameter int                            ADDR_W      = 25,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h0C000, 25'h08000, 25'h04000, 25'h0},
  parameter logic [ADDR_W-1:0]             REGION_END  = 25'h10000,
  parameter int                            ROM_INDEX   = 0,
  parameter int                            CFG_INDEX   = 1,
  parameter int                            CFG_BYTES   = 1,
  parameter int                            HOLD_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [NUM_REGIONS-1:0] rom_wr,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [8*CFG_BYTES-1:0] cfg,
  output logic                   cfg_valid,
  output logic                   core_hold,
  output logic                   load_done,
  output logic                   addr_err
`ifdef ROM_ROUTER_CHECKSUM_EN
  ,output logic [15:0]           checksum
`endif
);

  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]       ROM_IDX   = 8'(ROM_INDEX);
  localparam logic [7:0]       CFG_IDX   = 8'(CFG_INDEX);
  localparam logic [ADDR_W-1:0] CFG_LAST = ADDR_W'(CFG_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] rom_wr_q, rom_wr_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic [8*CFG_BYTES-1:0] cfg_q, cfg_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   addr_err_q, addr_err_d;

  logic [NUM_REGIONS-1:0] region_hot;
  logic [ADDR_W-1:0]      region_base;
  logic                   rom_start, load_start, rom_hit, rom_miss;

  // Last matching window wins, so ascending bases give the highest region at or below the address.
  always_comb begin
    region_hot  = '0;
    region_base = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (ioctl_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        region_hot    = '0;
        region_hot[i] = 1'b1;
        region_base   = REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
    rom_hit  = ioctl_wr && (ioctl_index == ROM_IDX) &&
               (ioctl_addr >= REGION_BASE[0 +: ADDR_W]) && (ioctl_addr < REGION_END);
    rom_miss = ioctl_wr && (ioctl_index == ROM_IDX) && !rom_hit;
  end

  assign rom_start = ioctl_download && (ioctl_index == ROM_IDX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (rom_start) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (rom_start) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A bad address in the same cycle as a new download still flags, so the set beats the clear.
  always_comb begin
    rom_wr_d    = rom_hit ? region_hot : '0;
    rom_addr_d  = rom_hit ? (ioctl_addr - region_base) : rom_addr_q;
    rom_data_d  = rom_hit ? ioctl_dout : rom_data_q;
    addr_err_d  = rom_miss ? 1'b1 : (load_start ? 1'b0 : addr_err_q);
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    if (ioctl_wr && (ioctl_index == CFG_IDX)) begin
      for (int k = 0; k < CFG_BYTES; k++) begin
        if (ioctl_addr == ADDR_W'(k)) cfg_d[8*k +: 8] = ioctl_dout;
      end
      if (ioctl_addr == CFG_LAST) cfg_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rom_wr_q    <= '0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_wr_q    <= rom_wr_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      addr_err_q  <= addr_err_d;
    end
  end

`ifdef ROM_ROUTER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Frozen once the load is done, unless a new download is starting this cycle.
  always_comb begin
    checksum_d = load_start ? 16'h0 : checksum_q;
    if (rom_hit && !(state_q == DONE && !load_start)) checksum_d = checksum_d + {8'h00, ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) checksum_q <= 16'h0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign rom_wr    = rom_wr_q;
  assign rom_addr  = rom_addr_q;
  assign rom_data  = rom_data_q;
  assign cfg       = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign addr_err  = addr_err_q;
  assign core_hold = (state_q != DONE);
  assign load_done = (state_q == DONE);

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router: vector table for routing/config, hand sequences for hold, reset and checksum.
module tb_ioctl_rom_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  rom_wr;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] cfg;
  logic        cfg_valid;
  logic        core_hold;
  logic        load_done;
  logic        addr_err;
`ifdef ROM_ROUTER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  ioctl_rom_router #(.CFG_BYTES(2)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .cfg            (cfg),
    .cfg_valid      (cfg_valid),
    .core_hold      (core_hold),
    .load_done      (load_done),
    .addr_err       (addr_err)
`ifdef ROM_ROUTER_CHECKSUM_EN
    ,.checksum      (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [3:0]  e_wr;
    logic [24:0] e_addr;
    logic [7:0]  e_data;
    logic        e_err;
    logic [15:0] e_cfg;
    logic        e_valid;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and compare the registered outputs after the edge.
  task automatic applyStimulus(input vec_t v, input int n);
    ioctl_download = v.dl;
    ioctl_index    = v.idx;
    ioctl_wr       = v.wr;
    ioctl_addr     = v.addr;
    ioctl_dout     = v.dout;
    tick();
    checkOutput($sformatf("vec%0d rom_wr", n),    32'(rom_wr),    32'(v.e_wr));
    checkOutput($sformatf("vec%0d rom_addr", n),  32'(rom_addr),  32'(v.e_addr));
    checkOutput($sformatf("vec%0d rom_data", n),  32'(rom_data),  32'(v.e_data));
    checkOutput($sformatf("vec%0d addr_err", n),  32'(addr_err),  32'(v.e_err));
    checkOutput($sformatf("vec%0d cfg", n),       32'(cfg),       32'(v.e_cfg));
    checkOutput($sformatf("vec%0d cfg_valid", n), 32'(cfg_valid), 32'(v.e_valid));
    checkOutput($sformatf("vec%0d core_hold", n), 32'(core_hold), 32'd1);
    checkOutput($sformatf("vec%0d load_done", n), 32'(load_done), 32'd0);
  endtask

  // Counts edges from the first low-download edge until load_done, capped to avoid hanging.
  task automatic waitDone(input string name);
    int n;
    n = 1;
    while (!load_done && n < 40) begin
      if (!core_hold) begin
        errors++;
        $display("[TB] FAIL %s core_hold dropped early: got 0 expected 1 at step %0d", name, n);
      end
      tick();
      n++;
    end
    checkOutput({name, " latency"}, 32'(n), 32'd17);
    checkOutput({name, " core_hold"}, 32'(core_hold), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'd0, 1'b1, 25'h00000, 8'hA5, 4'b0001, 25'h0000, 8'hA5, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 8'd0, 1'b1, 25'h04001, 8'hA5, 4'b0010, 25'h0001, 8'hA5, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 8'd0, 1'b0, 25'h04001, 8'hA5, 4'b0000, 25'h0001, 8'hA5, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 8'd0, 1'b1, 25'h0C0FF, 8'hA5, 4'b1000, 25'h00FF, 8'hA5, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 8'd0, 1'b1, 25'h07FFF, 8'h3C, 4'b0010, 25'h3FFF, 8'h3C, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 8'd0, 1'b1, 25'h08000, 8'h01, 4'b0100, 25'h0000, 8'h01, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 8'd0, 1'b1, 25'h10000, 8'h77, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 8'd0, 1'b0, 25'h00000, 8'h00, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 8'd1, 1'b1, 25'h00000, 8'h12, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h0012, 1'b0};
    vecs[9]  = '{1'b1, 8'd1, 1'b1, 25'h00001, 8'h34, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h3412, 1'b1};
    vecs[10] = '{1'b1, 8'd1, 1'b1, 25'h00002, 8'h56, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h3412, 1'b1};
    vecs[11] = '{1'b1, 8'd2, 1'b1, 25'h00000, 8'h99, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h3412, 1'b1};
    vecs[12] = '{1'b1, 8'd1, 1'b1, 25'h00000, 8'hAB, 4'b0000, 25'h0000, 8'h01, 1'b1, 16'h34AB, 1'b1};
    vecs[13] = '{1'b1, 8'd0, 1'b1, 25'h03FFF, 8'h0E, 4'b0001, 25'h3FFF, 8'h0E, 1'b1, 16'h34AB, 1'b1};
    vecs[14] = '{1'b1, 8'd0, 1'b1, 25'h0FFFF, 8'hF0, 4'b1000, 25'h3FFF, 8'hF0, 1'b1, 16'h34AB, 1'b1};

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    tick();
    tick();
    checkOutput("reset rom_wr",    32'(rom_wr),    32'd0);
    checkOutput("reset rom_addr",  32'(rom_addr),  32'd0);
    checkOutput("reset rom_data",  32'(rom_data),  32'd0);
    checkOutput("reset cfg",       32'(cfg),       32'd0);
    checkOutput("reset cfg_valid", 32'(cfg_valid), 32'd0);
    checkOutput("reset core_hold", 32'(core_hold), 32'd1);
    checkOutput("reset load_done", 32'(load_done), 32'd0);
    checkOutput("reset addr_err",  32'(addr_err),  32'd0);
`ifdef ROM_ROUTER_CHECKSUM_EN
    checkOutput("reset checksum",  32'(checksum),  32'd0);
`endif
    reset_n = 1'b1;
    tick();
    checkOutput("idle core_hold", 32'(core_hold), 32'd1);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Download drops after 10 more cycles; a write in that first low cycle must still route.
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h00010;
    ioctl_dout     = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    checkOutput("fall write rom_wr",   32'(rom_wr),   32'b0001);
    checkOutput("fall write rom_addr", 32'(rom_addr), 32'h10);
    checkOutput("fall write rom_data", 32'(rom_data), 32'h5A);
    waitDone("hold1");
    checkOutput("done addr_err sticky", 32'(addr_err), 32'd1);

    // Restart from DONE clears the flags.
    ioctl_download = 1'b1;
    tick();
    checkOutput("restart load_done", 32'(load_done), 32'd0);
    checkOutput("restart core_hold", 32'(core_hold), 32'd1);
    checkOutput("restart addr_err",  32'(addr_err),  32'd0);

    // Interrupt HOLD with a new download; the old countdown must not finish the load.
    ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("hold core_hold", 32'(core_hold), 32'd1);
    checkOutput("hold load_done", 32'(load_done), 32'd0);
    ioctl_download = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("reload load_done", 32'(load_done), 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h04002;
    ioctl_dout = 8'hC3;
    tick();
    ioctl_wr = 1'b0;
    checkOutput("pre-reset rom_wr", 32'(rom_wr), 32'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async rom_wr",    32'(rom_wr),    32'd0);
    checkOutput("async rom_data",  32'(rom_data),  32'd0);
    checkOutput("async core_hold", 32'(core_hold), 32'd1);
    checkOutput("async load_done", 32'(load_done), 32'd0);
    checkOutput("async cfg",       32'(cfg),       32'd0);
    checkOutput("async cfg_valid", 32'(cfg_valid), 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    checkOutput("post-reset rom_wr",    32'(rom_wr),    32'd0);
    checkOutput("post-reset core_hold", 32'(core_hold), 32'd1);
    ioctl_download = 1'b0;
    tick();
    waitDone("hold2");

`ifdef ROM_ROUTER_CHECKSUM_EN
    // Sum starts on the entry cycle; the out-of-range byte must not contribute.
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h0;
    ioctl_dout     = 8'hFF;
    tick();
    checkOutput("checksum first", 32'(checksum), 32'h00FF);
    ioctl_addr = 25'h1;
    tick();
    ioctl_addr = 25'h2;
    ioctl_dout = 8'h03;
    tick();
    checkOutput("checksum sum", 32'(checksum), 32'h0201);
    ioctl_addr = 25'h10000;
    ioctl_dout = 8'h55;
    tick();
    checkOutput("checksum excl", 32'(checksum), 32'h0201);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    waitDone("hold3");
    checkOutput("checksum done", 32'(checksum), 32'h0201);
    ioctl_download = 1'b1;
    tick();
    checkOutput("checksum clear", 32'(checksum), 32'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
